multi_precision_mac: RTL and testbench

MULTI_PRECISION_MAC -- requirements
Module: multi_precision_mac

---
 rtl/multi_precision_mac.sv | 199 +++++++++++++++++++
 tb/tb_multi_precision_mac.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_precision_mac.sv
// multi_precision_mac
//   Dot-product accumulator over packed low-precision operands. Each beat
//   carries K = 8/pd unsigned data elements in d and K signed weight elements
//   in w; the per-beat sum of products is added into a saturating signed
//   accumulator. One job = cfg_len beats, result presented on a valid/ready
//   output port.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   convtypeD/convtypeW   precision codes: 01 = 2-bit, 10 = 4-bit, 11 = 8-bit
//   cfg_len               beats per dot product (0 = empty job, result 0)
//   start                 job request, sampled only in IDLE
//   busy                  high whenever a job is in progress
//   cfg_err               one-cycle pulse when a start is rejected
//   in_valid/in_ready,d,w operand beat handshake
//   out_valid/out_ready   result handshake; out_acc/out_ovf held until taken
module multi_precision_mac #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              convtypeD,
    input  logic [1:0]              convtypeW,
    input  logic [CNT_W-1:0]        cfg_len,
    input  logic                    start,
    output logic                    busy,
    output logic                    cfg_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              d,
    input  logic [7:0]              w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    r_state;
    logic [1:0]                r_cfg_d;
    logic [1:0]                r_cfg_w;
    logic [CNT_W-1:0]          r_len;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_cfg_err;
    // Stage 0: accepted beat; stage 1: registered per-beat sum.
    logic [7:0]                r_d0;
    logic [7:0]                r_w0;
    logic                      r_v0;
    logic signed [16:0]        r_s1;
    logic                      r_v1;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_ovf;

    logic                      w_cfg_bad;
    logic signed [16:0]        w_sum;
    logic [7:0]                w_d_sh;
    logic [7:0]                w_w_sh;
    logic signed [16:0]        w_de;
    logic signed [16:0]        w_we;
    logic [3:0]                w_pd;
    logic [3:0]                w_pw;
    logic [ACC_W:0]            w_acc_sum;
    logic                      w_sat_hi;
    logic                      w_sat_lo;

    // Codes are ordered by width, so a numeric compare catches pw > pd.
    assign w_cfg_bad = (convtypeD == 2'b00) || (convtypeW == 2'b00) ||
                       (convtypeW > convtypeD);

    // Per-beat sum over the K packed element pairs of stage 0.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_sum  = '0;
        w_d_sh = '0;
        w_w_sh = '0;
        w_de   = '0;
        w_we   = '0;
        w_pd   = (r_cfg_d == 2'b01) ? 4'd2 : (r_cfg_d == 2'b10) ? 4'd4 : 4'd8;
        w_pw   = (r_cfg_w == 2'b01) ? 4'd2 : (r_cfg_w == 2'b10) ? 4'd4 : 4'd8;
        for (int k = 0; k < 4; k++) begin
            w_d_sh = r_d0 >> (k * int'(w_pd));
            w_w_sh = r_w0 >> (k * int'(w_pw));
            case (r_cfg_d)
                2'b01:   w_de = 17'(w_d_sh[1:0]);
                2'b10:   w_de = 17'(w_d_sh[3:0]);
                default: w_de = 17'(w_d_sh);
            endcase
            case (r_cfg_w)
                2'b01:   w_we = 17'($signed(w_w_sh[1:0]));
                2'b10:   w_we = 17'($signed(w_w_sh[3:0]));
                default: w_we = 17'($signed(w_w_sh));
            endcase
            // Only the first 8/pd element slots exist for this data width.
            if ((k * int'(w_pd)) < 8) begin
                w_sum = w_sum + w_de * w_we;
            end
        end
    end

    // One guard bit: both operands are in range, so overflow shows up as the
    // top two bits of the widened sum disagreeing.
    assign w_acc_sum = {r_acc[ACC_W-1], r_acc} + (ACC_W+1)'(r_s1);
    assign w_sat_hi  = !w_acc_sum[ACC_W] &&  w_acc_sum[ACC_W-1];
    assign w_sat_lo  =  w_acc_sum[ACC_W] && !w_acc_sum[ACC_W-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cfg_d   <= '0;
            r_cfg_w   <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
            r_d0      <= '0;
            r_w0      <= '0;
            r_v0      <= 1'b0;
            r_s1      <= '0;
            r_v1      <= 1'b0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            r_v0      <= 1'b0;
            r_v1      <= r_v0;
            if (r_v0) begin
                r_s1 <= w_sum;
            end
            if (r_v1) begin
                if (w_sat_hi) begin
                    r_acc <= ACC_MAX;
                    r_ovf <= 1'b1;
                end else if (w_sat_lo) begin
                    r_acc <= ACC_MIN;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum[ACC_W-1:0];
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_cfg_d <= convtypeD;
                            r_cfg_w <= convtypeW;
                            r_len   <= cfg_len;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= (cfg_len == '0) ? DONE : RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        r_v0  <= 1'b1;
                        r_d0  <= d;
                        r_w0  <= w;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == r_len - CNT_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last beat is in stage 1 and stage 0 is empty: this edge
                    // performs the final accumulate.
                    if (r_v1 && !r_v0) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign cfg_err   = r_cfg_err;
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_multi_precision_mac.sv
// Bench for multi_precision_mac: two instances (ACC_W = 24 and 16) share all
// inputs; every job is checked against an arithmetic reference model.
module tb_multi_precision_mac;

    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        convtypeD, convtypeW;
    logic [CNT_W-1:0]  cfg_len;
    logic              start, in_valid, out_ready;
    logic [7:0]        d, w;

    logic              busy_a, cfg_err_a, in_ready_a, out_valid_a, out_ovf_a;
    logic signed [23:0] out_acc_a;
    logic              busy_b, cfg_err_b, in_ready_b, out_valid_b, out_ovf_b;
    logic signed [15:0] out_acc_b;

    int n_cmp = 0;
    int n_err = 0;

    bit [7:0] q_d[$];
    bit [7:0] q_w[$];

    longint got_acc_a, got_acc_b;
    bit     got_ovf_a, got_ovf_b;

    always #5 clk = ~clk;

    multi_precision_mac #(.ACC_W(24), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .convtypeD(convtypeD), .convtypeW(convtypeW),
        .cfg_len(cfg_len), .start(start), .busy(busy_a), .cfg_err(cfg_err_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .d(d), .w(w),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_ovf(out_ovf_a)
    );

    multi_precision_mac #(.ACC_W(16), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .convtypeD(convtypeD), .convtypeW(convtypeW),
        .cfg_len(cfg_len), .start(start), .busy(busy_b), .cfg_err(cfg_err_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .d(d), .w(w),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_ovf(out_ovf_b)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int prec(input bit [1:0] c);
        return (c == 2'b01) ? 2 : (c == 2'b10) ? 4 : 8;
    endfunction

    // Sum of products of the packed elements, straight from the packing rules.
    function automatic longint beat_model(input bit [1:0] cd, input bit [1:0] cw,
                                          input bit [7:0] dv, input bit [7:0] wv);
        int pd = prec(cd);
        int pw = prec(cw);
        longint s = 0;
        for (int k = 0; k < 8 / pd; k++) begin
            int dk = int'(dv >> (k * pd)) % (1 << pd);
            int wk = int'(wv >> (k * pw)) % (1 << pw);
            if (wk >= (1 << (pw - 1))) wk -= (1 << pw);
            s += longint'(dk * wk);
        end
        return s;
    endfunction

    task automatic job_model(input bit [1:0] cd, input bit [1:0] cw, input int n,
                             input int acc_w, output longint acc, output bit ovf);
        longint hi = (longint'(1) << (acc_w - 1)) - 1;
        longint lo = -(longint'(1) << (acc_w - 1));
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += beat_model(cd, cw, q_d[i], q_w[i]);
            if (acc > hi) begin acc = hi; ovf = 1'b1; end
            else if (acc < lo) begin acc = lo; ovf = 1'b1; end
        end
    endtask

    // Entered and left at posedge+1. Runs one job with beats from q_d/q_w.
    task automatic run_job(input string tag, input bit [1:0] cd, input bit [1:0] cw,
                           input int len, input int gap_pct, input int hold,
                           input bit poke);
        longint exp_a, exp_b;
        bit     eo_a, eo_b;
        int     i;
        logic signed [23:0] cap;
        job_model(cd, cw, len, 24, exp_a, eo_a);
        job_model(cd, cw, len, 16, exp_b, eo_b);

        convtypeD = cd; convtypeW = cw; cfg_len = CNT_W'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            // Must be ignored: config is latched only at an accepted start.
            convtypeD = 2'b01; convtypeW = 2'b11; cfg_len = CNT_W'(len + 3);
        end
        check({tag, "_busy_after_start"}, busy_a, 1);
        check({tag, "_no_cfg_err"}, cfg_err_a, 0);

        if (len > 0) begin
            i = 0;
            for (int cyc = 0; cyc < 400 && i < len; cyc++) begin
                bit v = ($urandom_range(99) >= gap_pct);
                in_valid = v;
                d = v ? q_d[i] : 8'($urandom);
                w = v ? q_w[i] : 8'($urandom);
                if (poke && i == len - 1) start = 1'b1;
                if (v) check({tag, "_in_ready_run"}, in_ready_a, 1);
                @(posedge clk); #1;
                start = 1'b0;
                if (poke) check({tag, "_busy_start_ignored"}, cfg_err_a, 0);
                if (v) i++;
            end
            if (i < len) check({tag, "_beat_budget"}, i, len);
            in_valid = 1'b0;
            d = 8'($urandom);
            w = 8'($urandom);
            check({tag, "_drain_in_ready"}, in_ready_a, 0);
            check({tag, "_drain_busy"}, busy_a, 1);
            @(posedge clk); #1;
            check({tag, "_valid_lat1"}, out_valid_a, 0);
            @(posedge clk); #1;
        end
        check({tag, "_valid_lat2"}, out_valid_a, 1);
        check({tag, "_valid_b"}, out_valid_b, 1);
        check({tag, "_done_in_ready"}, in_ready_a, 0);
        check({tag, "_acc24"}, out_acc_a, exp_a);
        check({tag, "_ovf24"}, out_ovf_a, eo_a);
        check({tag, "_acc16"}, out_acc_b, exp_b);
        check({tag, "_ovf16"}, out_ovf_b, eo_b);
        got_acc_a = out_acc_a; got_ovf_a = out_ovf_a;
        got_acc_b = out_acc_b; got_ovf_b = out_ovf_b;

        cap = out_acc_a;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (h == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_hold_valid"}, out_valid_a, 1);
            check({tag, "_hold_acc"}, out_acc_a, cap);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid_a, 0);
        check({tag, "_idle_busy"}, busy_a, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        convtypeD = 2'b00; convtypeW = 2'b00; cfg_len = '0;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0; w = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_acc", out_acc_a, 0);
        check("rst_out_ovf", out_ovf_a, 0);
        check("rst_cfg_err", cfg_err_a, 0);
        rst_n = 1'b1;

        // 8x8, three beats; a start on the first edge after reset release.
        q_d = '{8'd200, 8'd10, 8'd255};
        q_w = '{8'hFD, 8'd5, 8'd127};
        run_job("r032", 2'b11, 2'b11, 3, 0, 0, 1'b0);
        check("r032_const_acc", got_acc_a, 31835);
        check("r032_const_ovf", got_ovf_a, 0);

        q_d = '{8'h3F}; q_w = '{8'h8F};
        run_job("r033", 2'b10, 2'b10, 1, 0, 0, 1'b0);
        check("r033_const_acc", got_acc_a, -39);

        q_d = '{8'hFF}; q_w = '{8'h6D};
        run_job("r034", 2'b01, 2'b01, 1, 0, 0, 1'b0);
        check("r034_const_acc", got_acc_a, -3);

        q_d = '{8'd255, 8'd255}; q_w = '{8'd127, 8'd127};
        run_job("r035", 2'b11, 2'b11, 2, 0, 0, 1'b0);
        check("r035_const_acc16", got_acc_b, 32767);
        check("r035_const_ovf16", got_ovf_b, 1);
        check("r035_const_acc24", got_acc_a, 64770);
        check("r035_const_ovf24", got_ovf_a, 0);

        q_d = '{8'd255, 8'd255}; q_w = '{8'h80, 8'h80};
        run_job("sat_neg", 2'b11, 2'b11, 2, 0, 0, 1'b0);
        check("sat_neg_acc16", got_acc_b, -32768);
        check("sat_neg_ovf16", got_ovf_b, 1);

        q_d.delete(); q_w.delete();
        run_job("len0", 2'b11, 2'b10, 0, 0, 1, 1'b0);
        check("len0_acc", got_acc_a, 0);

        // Flow control: gaps, late out_ready, start and config changes mid-job.
        q_d.delete(); q_w.delete();
        for (int i = 0; i < 5; i++) begin
            q_d.push_back(8'($urandom));
            q_w.push_back(8'($urandom));
        end
        run_job("r036", 2'b10, 2'b01, 5, 40, 5, 1'b1);

        // Rejected configurations.
        convtypeD = 2'b10; convtypeW = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pw_gt_pd_pulse", cfg_err_a, 1);
        check("err_pw_gt_pd_busy", busy_a, 0);
        @(posedge clk); #1;
        check("err_pulse_one_cycle", cfg_err_a, 0);
        check("err_still_idle", busy_a, 0);
        convtypeD = 2'b00; convtypeW = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_zero_code_pulse", cfg_err_a, 1);
        check("err_zero_code_busy", busy_a, 0);

        // Reset in the middle of RUN.
        convtypeD = 2'b11; convtypeW = 2'b11; cfg_len = CNT_W'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; d = 8'd100; w = 8'd50;
        repeat (3) @(posedge clk);
        #1;
        check("mid_run_busy", busy_a, 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_in_ready", in_ready_a, 0);
        check("arst_out_valid", out_valid_a, 0);
        check("arst_out_acc", out_acc_a, 0);
        check("arst_out_ovf", out_ovf_a, 0);
        check("arst_cfg_err", cfg_err_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q_d = '{8'd7, 8'd9}; q_w = '{8'hF0, 8'd3};
        run_job("post_rst", 2'b11, 2'b11, 2, 0, 0, 1'b0);

        // Random legal jobs.
        for (int j = 0; j < 10; j++) begin
            bit [1:0] cd = 2'($urandom_range(3, 1));
            bit [1:0] cw = 2'($urandom_range(int'(cd), 1));
            int len = int'($urandom_range(6, 1));
            q_d.delete(); q_w.delete();
            for (int i = 0; i < len; i++) begin
                q_d.push_back(8'($urandom));
                q_w.push_back(8'($urandom));
            end
            run_job($sformatf("rnd%0d", j), cd, cw, len, 25,
                    int'($urandom_range(2)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
